// File: rtl/cv_pkg.sv
// Shared constants and helpers for the serial Excess-3 <-> BCD converter.
// Holds the +/-3 constant, mode encodings and per-mode valid code ranges.
package cv_pkg;

  // Constant 3, consumed LSB first: k=1 on bits 0,1 and k=0 on bits 2,3.
  localparam logic [3:0] CV_K = 4'b0011;

  typedef enum logic {
    CV_XS3_TO_BCD = 1'b0,
    CV_BCD_TO_XS3 = 1'b1
  } cv_mode_e;

  // Valid input code ranges, inclusive.
  localparam logic [3:0] CV_XS3_MIN = 4'd3;
  localparam logic [3:0] CV_XS3_MAX = 4'd12;
  localparam logic [3:0] CV_BCD_MIN = 4'd0;
  localparam logic [3:0] CV_BCD_MAX = 4'd9;

  function automatic logic cv_k_bit(input logic [1:0] b);
    logic [3:0] k;
    k = CV_K;
    return k[b];
  endfunction

  // Range test written as an offset compare so both modes share one form.
  function automatic logic cv_code_valid(
    input logic       mode,
    input logic [3:0] v
  );
    logic [3:0] lo;
    logic [3:0] hi;
    if (mode == CV_BCD_TO_XS3) begin
      lo = CV_BCD_MIN;
      hi = CV_BCD_MAX;
    end else begin
      lo = CV_XS3_MIN;
      hi = CV_XS3_MAX;
    end
    return (v - lo) <= (hi - lo);
  endfunction

endpackage

// File: rtl/cv_bit_alu.sv
// One-bit add/subtract-constant cell for the serial converter.
// Ports: x_i data bit, c_i carry/borrow in, k_i constant bit, mode_i; z_o sum, c_o carry out.
module cv_bit_alu
  import cv_pkg::*;
(
  input  logic x_i,
  input  logic c_i,
  input  logic k_i,
  input  logic mode_i,
  output logic z_o,
  output logic c_o
);

  logic xe;

  // Borrow of x-k-c equals carry of ~x+k+c, so subtract just inverts x
  // on the carry path; the sum bit is identical for both modes.
  always_comb begin
    xe  = (mode_i == CV_BCD_TO_XS3) ? x_i : ~x_i;
    z_o = x_i ^ c_i ^ k_i;
    c_o = (xe & k_i) | (xe & c_i) | (k_i & c_i);
  end

endmodule

// File: rtl/serial_code_converter.sv
// Bit-serial LSB-first Excess-3 <-> BCD converter with Mealy output Z.
// Ports: Clk, Rst (async active low), En strobe, X bit, Mode; Z, Digit_Done,
// Word_Done, Err. Define CV_ERR_CHECK_EN to build invalid-code detection.
module serial_code_converter
  import cv_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic En,
  input  logic X,
  input  logic Mode,
  output logic Z,
  output logic Digit_Done,
  output logic Word_Done,
  output logic Err
);

  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DIGITS - 1);

  logic [1:0]       b_q;
  logic [CNT_W-1:0] d_q;
  logic             c_q;
  logic             m_q;
  logic             dd_q;
  logic             wd_q;

  logic word_start;
  logic last_digit;
  logic digit_end;
  logic mode_eff;
  logic c_in;
  logic k;
  logic z_raw;
  logic c_nxt;

  always_comb begin
    word_start = (b_q == 2'd0) && (d_q == '0);
    last_digit = (d_q == D_LAST);
    digit_end  = (b_q == 2'd3);
    mode_eff   = word_start ? Mode : m_q;
    c_in       = (b_q == 2'd0) ? 1'b0 : c_q;
    k          = cv_k_bit(b_q);
  end

  cv_bit_alu u_alu (
    .x_i    (X),
    .c_i    (c_in),
    .k_i    (k),
    .mode_i (mode_eff),
    .z_o    (z_raw),
    .c_o    (c_nxt)
  );

  assign Z = En & Rst & z_raw;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      b_q  <= 2'd0;
      d_q  <= '0;
      c_q  <= 1'b0;
      m_q  <= 1'b0;
      dd_q <= 1'b0;
      wd_q <= 1'b0;
    end else begin
      dd_q <= En & digit_end;
      wd_q <= En & digit_end & last_digit;
      if (En) begin
        m_q <= mode_eff;
        c_q <= c_nxt;
        b_q <= b_q + 2'd1;
        if (digit_end) begin
          d_q <= last_digit ? '0 : d_q + 1'b1;
        end
      end
    end
  end

  assign Digit_Done = dd_q;
  assign Word_Done  = wd_q;

`ifdef CV_ERR_CHECK_EN
  logic [2:0] sh_q;
  logic       err_q;
  logic [3:0] digit;

  // Bits 0..2 sit in sh_q by bit 3; X completes the digit.
  assign digit = {X, sh_q};

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sh_q  <= 3'd0;
      err_q <= 1'b0;
    end else begin
      err_q <= En & digit_end & ~cv_code_valid(mode_eff, digit);
      if (En) begin
        sh_q <= {X, sh_q[2:1]};
      end
    end
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_code_converter.sv
// Directed bench for serial_code_converter (DIGITS=2).
// Checks Z per bit and pulse outputs after each accepting edge.
module tb_serial_code_converter;

`ifdef CV_ERR_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic En = 1'b0;
  logic X = 1'b0;
  logic Mode = 1'b0;
  logic Z;
  logic Digit_Done;
  logic Word_Done;
  logic Err;

  int compared = 0;
  int mismatched = 0;

  always #5 Clk = ~Clk;

  serial_code_converter #(.DIGITS(2)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .En         (En),
    .X          (X),
    .Mode       (Mode),
    .Z          (Z),
    .Digit_Done (Digit_Done),
    .Word_Done  (Word_Done),
    .Err        (Err)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic send_digit(
    input string      tag,
    input logic [3:0] v,
    input logic       m0,
    input logic       mr,
    input logic [3:0] exp,
    input logic       last,
    input logic       bad,
    input int         gap
  );
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      X = v[i];
      Mode = (i == 0) ? m0 : mr;
      En = 1'b1;
      #1;
      chk($sformatf("%s z%0d", tag, i), Z, exp[i]);
      @(posedge Clk);
      #1;
      chk($sformatf("%s dd%0d", tag, i), Digit_Done, i == 3);
      chk($sformatf("%s wd%0d", tag, i), Word_Done, (i == 3) && last);
      chk($sformatf("%s err%0d", tag, i), Err, (i == 3) && bad && ERR_ON);
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge Clk);
          En = 1'b0;
          X = 1'b1;
          Mode = ~mr;
          #1;
          chk($sformatf("%s gapz%0d", tag, i), Z, 1'b0);
          @(posedge Clk);
          #1;
          chk($sformatf("%s gapdd%0d", tag, i), Digit_Done, 1'b0);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 1'b0;
    En = 1'b1;
    X = 1'b1;
    Mode = 1'b0;
    #2;
    chk("rst z", Z, 1'b0);
    @(posedge Clk);
    #1;
    chk("rst dd", Digit_Done, 1'b0);
    chk("rst wd", Word_Done, 1'b0);
    chk("rst err", Err, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    En = 1'b0;

    // XS3->BCD: 5 -> 2, 12 -> 9
    send_digit("w1d0", 4'h5, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 0);
    send_digit("w1d1", 4'hC, 1'b0, 1'b0, 4'h9, 1'b1, 1'b0, 0);

    // XS3->BCD: 3 -> 0, invalid 0 -> 13 (wrap)
    send_digit("w2d0", 4'h3, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 0);
    send_digit("w2d1", 4'h0, 1'b0, 1'b0, 4'hD, 1'b1, 1'b1, 0);

    // BCD->XS3 latched at word start; later Mode=0 ignored
    send_digit("w3d0", 4'h7, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 0);
    send_digit("w3d1", 4'h9, 1'b0, 1'b0, 4'hC, 1'b1, 1'b0, 0);

    // En gaps between bits: 6 -> 3, 9 -> 6
    send_digit("w4d0", 4'h6, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 2);
    send_digit("w4d1", 4'h9, 1'b0, 1'b0, 4'h6, 1'b1, 1'b0, 1);

    // BCD->XS3: invalid 10 -> 13, 0 -> 3
    send_digit("w5d0", 4'hA, 1'b1, 1'b1, 4'hD, 1'b0, 1'b1, 0);
    send_digit("w5d1", 4'h0, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0, 0);

    // Partial digit in add mode, then reset
    @(negedge Clk);
    X = 1'b1;
    Mode = 1'b1;
    En = 1'b1;
    #1;
    chk("part z0", Z, 1'b0);
    @(negedge Clk);
    X = 1'b1;
    #1;
    chk("part z1", Z, 1'b1);
    @(posedge Clk);
    #1;
    chk("part dd", Digit_Done, 1'b0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("midrst z", Z, 1'b0);
    @(posedge Clk);
    #1;
    chk("midrst dd", Digit_Done, 1'b0);
    chk("midrst wd", Word_Done, 1'b0);
    chk("midrst err", Err, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    En = 1'b0;

    // Mode re-sampled after reset: 4 -> 1, 8 -> 5
    send_digit("w6d0", 4'h4, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 0);
    send_digit("w6d1", 4'h8, 1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 0);

    @(negedge Clk);
    En = 1'b0;
    #1;
    chk("idle z", Z, 1'b0);
    @(posedge Clk);
    #1;
    chk("idle dd", Digit_Done, 1'b0);
    chk("idle wd", Word_Done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_code_converter.md
# serial_code_converter

Bit-serial, LSB-first decimal code converter: successor of the single-digit Excess-3→BCD lab converter, generalised to multi-digit words, two conversion directions, a bit-enable handshake and invalid-code detection. Sits between a serial digit source and a serial sink. Output is Mealy: Z is valid in the same cycle as X. One digit = 4 consecutive accepted bits; one word = DIGITS digits.

## Interface
- DIGITS, 4, digits per word (≥1); sets Word_Done period.
- CNT_W, $clog2(DIGITS) (min 1), digit-counter width (derived; do not override).
- Clk  in  1  clock, rising edge active.
- Rst  in  1  asynchronous, active-low reset.
- En  in  1  bit strobe; X accepted and Z valid only when En=1.
- X  in  1  serial input bit, LSB of each digit first.
- Mode  in  1  0: Excess-3→BCD (subtract 3); 1: BCD→Excess-3 (add 3). Sampled on bit 0 of each word only.
- Z  out  1  serial converted bit (combinational from X, state, Mode latch).
- Digit_Done  out  1  registered one-cycle pulse after 4th bit of each digit.
- Word_Done  out  1  registered one-cycle pulse after last bit of last digit.
- Err  out  1  registered one-cycle pulse, coincident with Digit_Done, for an invalid input digit.

## Operation
- State: bit index b (2 bits), digit index d (CNT_W bits), carry/borrow c, latched mode m, 3-bit shift of received X bits (error check only).
- Constant K = 0011, LSB first: k=1 at b=0,1; k=0 at b=2,3.
- Add (m=1): Z = X^c^k; c' = X&k | X&c | k&c.
- Subtract (m=0): Z = X^c^k; c' = ~X&k | ~X&c | k&c.
- Effective mode for the bit: Mode when b=0 and d=0, else m. m loads at that bit.
- c cleared at every digit start (b=0 uses c=0); final carry/borrow discarded, result wraps mod 16.
- En=0: Z=0, no state change, pulses not generated.
- Counters: b increments per accepted bit, wraps 3→0 and increments d; d wraps DIGITS-1→0.
- Valid codes: Excess-3 input 0011..1100; BCD input 0000..1001. Checked using 3 stored bits plus X at b=3.

## Timing
- Reset (Rst=0, async): b=0, d=0, c=0, m=0, shift=0, Digit_Done=Word_Done=Err=0; Z=0 while Rst=0.
- Z: zero latency, valid from X settle until next rising edge; sample before edge.
- Digit_Done/Err: high exactly one cycle following the edge that accepts b=3.
- Word_Done: same cycle as the final Digit_Done of a word.
- Bits may be separated by any number of En=0 cycles; pulses fire only after the accepting edge.
- Reset mid-digit/word: partial digit discarded, no pulses; next accepted bit is bit 0 of digit 0 and re-samples Mode.
- Mode changes mid-word are ignored until next word start.

## Configuration
- CV_ERR_CHECK_EN defined: shift register and validity check built; Err pulses as specified.
- Undefined: no shift register; Err tied to 0; conversion and all timing unchanged.

## Structure
- Package cv_pkg: K constant, mode encodings (CV_XS3_TO_BCD=0, CV_BCD_TO_XS3=1), valid-range bounds per mode.
- Sub-module cv_bit_alu: combinational one-bit add/subtract-constant cell (X, c, k, mode → Z, c'); top holds counters, mode latch, error check, pulse registers.

## Test plan
- Mode=0, DIGITS=1, X digit 0101 LSB-first, En=1 -> Z bits 0010, Digit_Done and Word_Done pulse after bit 3, Err=0.
- Mode=0, digits 1100 then 0011 (DIGITS=2) -> Z 1001 then 0000; Word_Done only after second digit.
- Mode=1 at word start then toggled mid-word, digits 0111, 1001 -> Z 1010, 1100 (add 3 held for whole word).
- Mode=0, invalid digit 0000 with CV_ERR_CHECK_EN -> Z 1101 (wrap), Err pulses with Digit_Done; without macro Err stays 0.
- En toggled 1,0,0,1,... across digit 0110 (Mode=0) -> Z 0011 on En=1 cycles only, Z=0 on En=0 cycles, Digit_Done once.
- Rst low after 2 bits of a digit, release, send 0100 (Mode=0) -> no pulse from partial digit; Z 0001, then Digit_Done.
